pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. It sits beside the forwarding unit and owns the enable/flush strobes of every pipeline register. It resolves three hazard classes:
- load-use data hazards, by inserting a bubble;
- taken branches and jumps, by squashing IF/ID and ID/EX;
- slow data-memory accesses, by freezing the whole pipeline until `mem_ack` arrives or a watchdog expires.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum freeze cycles waiting for `mem_ack` before `mem_err`. Legal range is ≥2.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `reset2`  in  1  asynchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the ID instruction actually reads `rs1`/`rs2`.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_is_load`  in  1  the EX instruction is a load (opcode 0000011).
- `br_taken`  in  1  EX resolved a taken branch, JAL or JALR.
- `mem_req`  in  1  MEM stage is issuing a data-memory access.
- `mem_ack`  in  1  data memory completes the access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  pipeline register enables.
- `ifid_flush`, `idex_flush`  out  1 each  synchronous clear of the register (inserts a NOP).
- `mem_err`  out  1  one-cycle pulse on watchdog expiry.
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each  performance counters. Present only with the configuration macro.

## Operation
- State register: RUN, FREEZE. Watchdog counter `wcnt` is `clog2(TIMEOUT)+1` bits.
- The load-use hazard `lu` is 1 when all of the following hold:
  - `ex_is_load` is 1;
  - `ex_rd` is not 0;
  - `id_use_rs1` is set and `id_rs1` equals `ex_rd`, or `id_use_rs2` is set and `id_rs2` equals `ex_rd`.
- The freeze condition `frz` is 1 when either:
  - the state is RUN, `mem_req` is 1 and `mem_ack` is 0; or
  - the state is FREEZE, `mem_ack` is 0 and `wcnt` is below `TIMEOUT-1`.
- Output priority, highest first:
  - **Freeze** (`frz`=1): all five enables are 0 and both flushes are 0.
  - **Flush** (`br_taken`=1): all enables are 1, `ifid_flush`=1 and `idex_flush`=1. The load-use stall is suppressed because the dependent instruction is being squashed.
  - **Load-use** (`lu`=1): `pc_en`=0, `ifid_en`=0, `idex_flush`=1. All other enables are 1.
  - **Otherwise:** all enables are 1 and both flushes are 0.
- State transitions:
  - RUN→FREEZE when `mem_req`=1 and `mem_ack`=0; `wcnt` loads 1.
  - FREEZE→RUN when `mem_ack`=1. That cycle is the release cycle; `wcnt` clears.
  - FREEZE→RUN on timeout: `wcnt` reaches `TIMEOUT-1` with `mem_ack`=0. That cycle is the release cycle, `mem_err` is 1, and `wcnt` clears.
  - Otherwise FREEZE stays in FREEZE and `wcnt` increments.
- In the release cycle, the flush and load-use rules apply to the current inputs. A `br_taken` held during a freeze takes effect there.
- `mem_ack` while in RUN with `mem_req`=1 is a zero-wait access: no freeze.
- `mem_ack` without `mem_req` in RUN is ignored.

## Timing
- Hazard outputs are combinational from the inputs and the current state. There is zero-cycle latency from a hazard to its strobe.
- A load-use stall lasts exactly 1 cycle: the load moves to MEM, so `lu` drops naturally.
- A branch flush lasts 1 cycle per `br_taken` cycle.
- A freeze of N wait cycles holds the enables low for N cycles (N counts the entry cycle). The maximum is `TIMEOUT-1` frozen cycles followed by one release cycle.
- While `reset2`=0, all outputs are held at these values:
  - state RUN, `wcnt` 0;
  - all enables 0, both flushes 0;
  - `mem_err` 0;
  - both counters 0.
- A reset mid-freeze aborts the wait immediately, with no `mem_err`.
- Reset release is synchronised by the system. The first edge after release evaluates normally.

## Configuration
- Macro `HAZ_PERF_CNT_EN`.
- **Defined:**
  - `stall_cnt` increments on every cycle where `pc_en`=0, i.e. freeze or load-use.
  - `flush_cnt` increments on every cycle where `ifid_flush`=1.
  - Both counters wrap modulo 2^`CNT_W`.
- **Undefined:** the counter registers and both ports are absent. Hazard behaviour is identical.

## Test plan
- **Load-use stall.** Drive `ex_is_load`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 for one cycle. Required: `pc_en`=0, `ifid_en`=0, `idex_flush`=1 for exactly that cycle. Repeat with `ex_rd`=0: no stall.
- **Branch beats load-use.** Same hazard as above plus `br_taken`=1. Required: `ifid_flush`=`idex_flush`=1, `pc_en`=1. With the macro defined, `flush_cnt` goes 0→1 and `stall_cnt` stays 0.
- **Memory wait.** Drive `mem_req`=1 with `mem_ack` rising on the 4th cycle. Required: all enables 0 for 3 cycles and 1 on the ack cycle, state back in RUN, `mem_err`=0, `stall_cnt`=3.
- **Watchdog.** `TIMEOUT`=16, `mem_req`=1, `mem_ack` held at 0. Required: 15 frozen cycles, then a release cycle with `mem_err`=1 for one cycle. A new freeze starts on the next cycle if `mem_req` persists.
- **Branch held through a freeze.** `br_taken`=1 during a 2-cycle freeze. Required: no flush while frozen; `ifid_flush`=`idex_flush`=1 in the release cycle.
- **Reset mid-freeze.** Pull `reset2` low in the 2nd freeze cycle. Required: outputs go to their reset values asynchronously, before the next edge. After release, the state is RUN, with no `mem_err` and counters at 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage RV32I pipeline. It resolves load-use
// bubbles, branch/jump squashes, and data-memory wait freezes. A watchdog
// releases the freeze with a one-cycle mem_err pulse.
// The optional performance counters (stall_cnt, flush_cnt) are built only
// when the macro HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset2,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int WCNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              lu;
    logic              frz;
    logic              timeout_hit;

    // State register and watchdog counter; reset aborts any wait in progress.
    always_ff @(posedge clk or negedge reset2) begin
        if (!reset2) begin
            state_q <= RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Hazard detection, next-state logic and strobe generation.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        mem_err     = 1'b0;

        // x0 never carries a real dependency, so a load to x0 never stalls.
        lu = ex_is_load && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) ||
              (id_use_rs2 && (id_rs2 == ex_rd)));

        timeout_hit = (state_q == FREEZE) && !mem_ack && (wcnt_q >= WCNT_LAST);

        frz = ((state_q == RUN) && mem_req && !mem_ack) ||
              ((state_q == FREEZE) && !mem_ack && (wcnt_q < WCNT_LAST));

        case (state_q)
            RUN: begin
                // A same-cycle ack is a zero-wait access and never freezes.
                if (mem_req && !mem_ack) begin
                    state_d = FREEZE;
                    wcnt_d  = WCNT_ONE;
                end
            end
            FREEZE: begin
                if (mem_ack || timeout_hit) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d  = wcnt_q + WCNT_ONE;
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase

        // Freeze outranks flush, which outranks the load-use bubble; a branch
        // squashes the dependent instruction so its stall is unnecessary.
        if (frz) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end

        mem_err = timeout_hit;

        // While reset is asserted every strobe is forced low immediately.
        if (!reset2) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            mem_err    = 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Next values for the performance counters; both wrap naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && reset2) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ifid_flush) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset2) begin
        if (!reset2) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (TIMEOUT=16). Counter checks are
// compiled in only when HAZ_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset2;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_is_load, br_taken, mem_req, mem_ack;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, mem_err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int vecs = 0;
    int errs = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .reset2(reset2),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .br_taken(br_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mem_err(mem_err)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobes packed as {pc,ifid,idex,exmem,memwb,ifid_fl,idex_fl,mem_err}.
    function automatic logic [31:0] strb();
        return {24'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, mem_err};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0;
        br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset2 = 1'b0;
        #1;
        cyc();
        reset2 = 1'b1;
    endtask

    localparam logic [31:0] IDLE   = 32'b1111_1000;
    localparam logic [31:0] FROZEN = 32'b0000_0000;
    localparam logic [31:0] LUSTL  = 32'b0011_1010;
    localparam logic [31:0] FLUSH  = 32'b1111_1110;
    localparam logic [31:0] WDREL  = 32'b1111_1001;

    initial begin
        clr_in();
        // Reset with a branch pending: every strobe must still be low.
        reset2 = 1'b0;
        br_taken = 1'b1;
        #1;
        chk("reset_strobes", strb(), FROZEN);
`ifdef HAZ_PERF_CNT_EN
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_flush_cnt", flush_cnt, 32'd0);
`endif
        cyc();
        br_taken = 1'b0;
        reset2 = 1'b1;
        #1;
        chk("idle_after_reset", strb(), IDLE);
        cyc();

        // Load-use on rs2.
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        #1;
        chk("lu_rs2", strb(), LUSTL);
        cyc();
        ex_is_load = 1'b0;
        #1;
        chk("lu_drops", strb(), IDLE);
        cyc();
        // Load to x0 never stalls.
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        chk("lu_x0", strb(), IDLE);
        cyc();
        // Load-use on rs1; rs1 match without use flag is no hazard.
        clr_in();
        ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
        #1;
        chk("lu_rs1", strb(), LUSTL);
        id_use_rs1 = 1'b0;
        #1;
        chk("lu_rs1_unused", strb(), IDLE);
        cyc();

        // Branch beats load-use.
        clr_in();
        do_reset();
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        br_taken = 1'b1;
        #1;
        chk("br_over_lu", strb(), FLUSH);
`ifdef HAZ_PERF_CNT_EN
        chk("flush_cnt_before", flush_cnt, 32'd0);
`endif
        cyc();
`ifdef HAZ_PERF_CNT_EN
        chk("flush_cnt_after", flush_cnt, 32'd1);
        chk("stall_cnt_br", stall_cnt, 32'd0);
`endif
        clr_in();

        // Memory wait: ack on the 4th cycle.
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("memwait_frozen", strb(), FROZEN);
            cyc();
        end
        mem_ack = 1'b1;
        #1;
        chk("memwait_release", strb(), IDLE);
        cyc();
`ifdef HAZ_PERF_CNT_EN
        chk("memwait_stall_cnt", stall_cnt, 32'd3);
`endif
        clr_in();
        #1;
        chk("memwait_back_run", strb(), IDLE);
        cyc();

        // Zero-wait access and ack without request.
        mem_req = 1'b1; mem_ack = 1'b1;
        #1;
        chk("zero_wait", strb(), IDLE);
        cyc();
        mem_req = 1'b0;
        #1;
        chk("ack_no_req", strb(), IDLE);
        cyc();
        clr_in();

        // Watchdog: 15 frozen cycles then a release with mem_err.
        mem_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("wd_frozen", strb(), FROZEN);
            cyc();
        end
        #1;
        chk("wd_release", strb(), WDREL);
        cyc();
        #1;
        chk("wd_refreeze", strb(), FROZEN);
        cyc();
        mem_req = 1'b0;
        #1;
        chk("wd_still_frozen", strb(), FROZEN);
        mem_ack = 1'b1;
        #1;
        chk("wd_ack_release", strb(), IDLE);
        cyc();
        clr_in();

        // Branch held through a 2-cycle freeze.
        mem_req = 1'b1; br_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("br_hold_frozen", strb(), FROZEN);
            cyc();
        end
        mem_ack = 1'b1;
        #1;
        chk("br_hold_release", strb(), FLUSH);
        cyc();
        clr_in();
        #1;
        chk("br_hold_after", strb(), IDLE);
        cyc();

        // Reset in the 2nd freeze cycle, asynchronously.
        mem_req = 1'b1;
        #1;
        chk("rst_frz_1", strb(), FROZEN);
        cyc();
        br_taken = 1'b1;
        #2;
        reset2 = 1'b0;
        #1;
        chk("rst_frz_async", strb(), FROZEN);
        cyc();
        clr_in();
        reset2 = 1'b1;
        #1;
        chk("rst_frz_run", strb(), IDLE);
`ifdef HAZ_PERF_CNT_EN
        chk("rst_frz_stall_cnt", stall_cnt, 32'd0);
        chk("rst_frz_flush_cnt", flush_cnt, 32'd0);
`endif
        cyc();
        mem_req = 1'b1;
        #1;
        chk("rst_frz_new_freeze", strb(), FROZEN);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
